attempt_lockout_ctrl: RTL
=========================

# attempt_lockout_ctrl

Arbitrates unlock attempts for the doorlock. It sits between the challenge-state compare logic (password buffer vs. stored password, master code compare) and the lock actuator and display. It counts consecutive failed attempts, enforces a timed lockout after too many failures, and grants unlock on a correct or master code. During lockout it blocks normal attempts and exposes the remaining lockout time for the display.

## Interface
Parameters:
- MAX_FAIL, 5, consecutive failures that trigger lockout; legal range 1..15
- LOCK_CYCLES, 50000000, base lockout duration in clk cycles; must be ≥1
- TIMER_W, 32, width of the lockout timer; must hold LOCK_CYCLES<<3

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- attempt  in  1  one-cycle pulse when the user confirms an entry in challenge
- match  in  1  user entry equals stored password; sampled only with attempt
- master_match  in  1  entry equals master code; sampled only with attempt
- accept  out  1  level; 1 when normal attempts are honoured
- unlock_pulse  out  1  one-cycle grant pulse
- fail_pulse  out  1  one-cycle rejection pulse
- locked_out  out  1  level; 1 during lockout
- fail_cnt  out  4  consecutive failure count
- lock_level  out  2  escalation level
- remaining  out  TIMER_W  lockout cycles left; 0 outside lockout

## Operation
- FSM states: READY, LOCKOUT. Reset state is READY.
- READY, attempt & master_match:
  - unlock_pulse.
  - fail_cnt←0, lock_level←0.
- READY, attempt & match & ~master_match:
  - unlock_pulse.
  - fail_cnt←0, lock_level←0.
- READY, attempt & ~match & ~master_match:
  - fail_pulse.
  - fail_cnt←fail_cnt+1.
  - If the new count equals MAX_FAIL, go to LOCKOUT and load remaining with the duration D.
- LOCKOUT:
  - remaining decrements by 1 each cycle.
  - When remaining==1, the next cycle enters READY with remaining=0 and fail_cnt=MAX_FAIL−1. A single further failure relocks.
  - On lockout exit, lock_level increments, saturating at 3.
- LOCKOUT, attempt & master_match:
  - Immediate exit to READY.
  - unlock_pulse; fail_cnt←0, lock_level←0, remaining←0.
- LOCKOUT, attempt without master_match:
  - Ignored. No pulse, no count change.
- Derived outputs:
  - accept = (state==READY).
  - locked_out = (state==LOCKOUT).
- match and master_match are don't-care when attempt=0.
- match and master_match both high is treated as master.

## Timing
- All outputs are registered.
- Reset values: accept=1, unlock_pulse=0, fail_pulse=0, locked_out=0, fail_cnt=0, lock_level=0, remaining=0, state READY.
- Latency: attempt in cycle N produces unlock_pulse or fail_pulse in cycle N+1. Pulses are exactly 1 cycle wide.
- State and remaining update in cycle N+1.
- On a failure that locks out, fail_pulse and locked_out both rise in N+1, with remaining=D.
- Lockout lasts exactly D cycles: locked_out is high for D consecutive cycles.
- An attempt arriving in the last lockout cycle (remaining==1) is ignored unless it is a master attempt.
- Back-to-back attempt pulses on consecutive cycles are each evaluated.
- fail_cnt saturates at 15; this is unreachable with legal MAX_FAIL and is kept as a safeguard.
- rst asserted mid-lockout immediately forces the reset values.

## Configuration
- Macro: LOCKOUT_ESCALATE_EN.
- Defined: D = LOCK_CYCLES << lock_level, evaluated at lockout entry. lock_level takes values 0..3, giving 1×, 2×, 4×, 8× durations.
- Undefined: D = LOCK_CYCLES always. lock_level is held at 0 and does not increment.
- Port list is identical in both builds.

## Test plan
Parameters for all scenarios: MAX_FAIL=3, LOCK_CYCLES=10.
- Correct entry: reset, then attempt with match=1 → unlock_pulse high 1 cycle in N+1; fail_cnt=0; accept stays 1.
- Lockout entry and exit: 3 failing attempts → fail_pulse ×3; fail_cnt 1,2,3; third failure raises locked_out with remaining=10. locked_out is high exactly 10 cycles. Then accept=1 and fail_cnt=2.
- Ignored attempts: during lockout, attempt with match=1 → no pulse and remaining keeps decrementing. Master attempt → unlock_pulse next cycle; fail_cnt=0; locked_out=0; remaining=0.
- Escalation with LOCKOUT_ESCALATE_EN defined: after the first lockout expires, one more failure → remaining=20. Repeated cycles give 40, 80, then 80 again (saturated). A correct unlock resets the next lockout to 10.
- Escalation with the macro undefined: same sequence → every lockout is 10 cycles and lock_level stays 0.
- Reset mid-lockout: assert rst at remaining=5 → all outputs immediately at their reset values. The next failing attempt gives fail_cnt=1.

Source files
------------

// File: rtl/attempt_lockout_ctrl.sv
// Unlock-attempt arbiter: counts consecutive failures, enforces a timed lockout, grants unlock.
// Optional LOCKOUT_ESCALATE_EN doubles the lockout duration per expired lockout (up to 8x).
module attempt_lockout_ctrl #(
  parameter int MAX_FAIL    = 5,
  parameter int LOCK_CYCLES = 50000000,
  parameter int TIMER_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               attempt,
  input  logic               match,
  input  logic               master_match,
  output logic               accept,
  output logic               unlock_pulse,
  output logic               fail_pulse,
  output logic               locked_out,
  output logic [3:0]         fail_cnt,
  output logic [1:0]         lock_level,
  output logic [TIMER_W-1:0] remaining
);

  typedef enum logic {READY = 1'b0, LOCKOUT = 1'b1} state_t;

  localparam logic [TIMER_W-1:0] LOCK_BASE     = TIMER_W'(LOCK_CYCLES);
  localparam logic [3:0]         FAIL_LIMIT    = 4'(MAX_FAIL);
  localparam logic [3:0]         FAIL_RELOCK   = 4'(MAX_FAIL - 1);

  state_t               state_q, state_d;
  logic [3:0]           fail_cnt_q, fail_cnt_d;
  logic [1:0]           lvl_q, lvl_d;
  logic [TIMER_W-1:0]   rem_q, rem_d;
  logic                 unlock_q, unlock_d;
  logic                 fail_q, fail_d;

  function automatic logic [3:0] sat_inc_cnt(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [1:0] sat_inc_lvl(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= READY;
      fail_cnt_q <= '0;
      lvl_q      <= '0;
      rem_q      <= '0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      lvl_q      <= lvl_d;
      rem_q      <= rem_d;
      unlock_q   <= unlock_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    lvl_d      = lvl_q;
    rem_d      = rem_q;
    unlock_d   = 1'b0;
    fail_d     = 1'b0;
    case (state_q)
      READY: begin
        if (attempt) begin
          if (master_match || match) begin
            unlock_d   = 1'b1;
            fail_cnt_d = '0;
            lvl_d      = '0;
          end else begin
            fail_d     = 1'b1;
            fail_cnt_d = sat_inc_cnt(fail_cnt_q);
            if (fail_cnt_d == FAIL_LIMIT) begin
              state_d = LOCKOUT;
`ifdef LOCKOUT_ESCALATE_EN
              rem_d   = LOCK_BASE << lvl_q;
`else
              rem_d   = LOCK_BASE;
`endif
            end
          end
        end
      end
      LOCKOUT: begin
        if (attempt && master_match) begin
          state_d    = READY;
          unlock_d   = 1'b1;
          fail_cnt_d = '0;
          lvl_d      = '0;
          rem_d      = '0;
        end else if (rem_q <= TIMER_W'(1)) begin
          // Expiry leaves one failure short of the limit so a single miss relocks.
          state_d    = READY;
          rem_d      = '0;
          fail_cnt_d = FAIL_RELOCK;
`ifdef LOCKOUT_ESCALATE_EN
          lvl_d      = sat_inc_lvl(lvl_q);
`endif
        end else begin
          rem_d = rem_q - TIMER_W'(1);
        end
      end
      default: state_d = READY;
    endcase
  end

  always_comb begin
    accept       = (state_q == READY);
    locked_out   = (state_q == LOCKOUT);
    unlock_pulse = unlock_q;
    fail_pulse   = fail_q;
    fail_cnt     = fail_cnt_q;
    lock_level   = lvl_q;
    remaining    = rem_q;
  end

endmodule
